// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: PC register and IF/ID pipeline latch feeding the load-use hazard check.
// Define FETCH_PERF_COUNTERS_EN to build the saturating stall/flush counters.
module if_id_fetch_stage #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] instr_addr,
  input  logic [31:0]     instr_in,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic [4:0]      if_id_rs1,
  output logic [4:0]      if_id_rs2,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count
);
  logic [XLEN-1:0] pc;
  assign instr_addr = pc;
  assign if_id_rs1  = if_id_instr[19:15];
  assign if_id_rs2  = if_id_instr[24:20];
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      pc          <= branch_target & ~XLEN'(3);
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc          <= pc + XLEN'(4);
      if_id_pc    <= pc;
      if_id_instr <= instr_in;
      if_id_valid <= 1'b1;
    end
  end
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stall_q, flush_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (branch_taken && ~&flush_q) flush_q <= flush_q + 32'd1;
      if (stall && !branch_taken && ~&stall_q) stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb_if_id_fetch_stage: table-driven check of fetch/IF-ID behaviour plus a long-stall sequence.
module tb_if_id_fetch_stage;
`ifdef FETCH_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    logic        r, s, b;
    logic [63:0] t;
    logic [63:0] pc, ipc;
    logic [31:0] ins;
    logic        v;
    logic [31:0] sc, fc;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [63:0] branch_target, instr_addr, if_id_pc;
  logic [31:0] instr_in, if_id_instr, stall_cycles, flush_count;
  logic        if_id_valid;
  logic [4:0]  if_id_rs1, if_id_rs2;
  int total = 0, bad = 0;
  vec_t vec[21];
  always #5 clk = ~clk;
  assign instr_in = 32'h00A00093 + instr_addr[31:0];
  if_id_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_addr(instr_addr), .instr_in(instr_in),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] pc_(input logic [31:0] x);
    return PERF ? x : 32'd0;
  endfunction
  task automatic check_state(input string tag, input vec_t e);
    chk({tag, "_addr"}, instr_addr, e.pc);
    chk({tag, "_ifpc"}, if_id_pc, e.ipc);
    chk({tag, "_instr"}, {32'd0, if_id_instr}, {32'd0, e.ins});
    chk({tag, "_valid"}, {63'd0, if_id_valid}, {63'd0, e.v});
    chk({tag, "_rs1"}, {59'd0, if_id_rs1}, {59'd0, e.ins[19:15]});
    chk({tag, "_rs2"}, {59'd0, if_id_rs2}, {59'd0, e.ins[24:20]});
    chk({tag, "_stallcnt"}, {32'd0, stall_cycles}, {32'd0, pc_(e.sc)});
    chk({tag, "_flushcnt"}, {32'd0, flush_count}, {32'd0, pc_(e.fc)});
  endtask
  initial begin
    vec_t e;
    vec[0]  = '{1, 0, 0, 64'h0,   64'h0,   64'h0,   32'h00000013, 0, 0, 0};
    vec[1]  = '{0, 0, 0, 64'h0,   64'h4,   64'h0,   32'h00A00093, 1, 0, 0};
    vec[2]  = '{0, 0, 0, 64'h0,   64'h8,   64'h4,   32'h00A00097, 1, 0, 0};
    vec[3]  = '{0, 1, 0, 64'h0,   64'h8,   64'h4,   32'h00A00097, 1, 1, 0};
    vec[4]  = '{0, 1, 0, 64'h0,   64'h8,   64'h4,   32'h00A00097, 1, 2, 0};
    vec[5]  = '{0, 1, 0, 64'h0,   64'h8,   64'h4,   32'h00A00097, 1, 3, 0};
    vec[6]  = '{0, 0, 0, 64'h0,   64'hC,   64'h8,   32'h00A0009B, 1, 3, 0};
    vec[7]  = '{0, 0, 0, 64'h0,   64'h10,  64'hC,   32'h00A0009F, 1, 3, 0};
    vec[8]  = '{0, 0, 0, 64'h0,   64'h14,  64'h10,  32'h00A000A3, 1, 3, 0};
    vec[9]  = '{0, 0, 0, 64'h0,   64'h18,  64'h14,  32'h00A000A7, 1, 3, 0};
    vec[10] = '{0, 0, 0, 64'h0,   64'h1C,  64'h18,  32'h00A000AB, 1, 3, 0};
    vec[11] = '{0, 0, 0, 64'h0,   64'h20,  64'h1C,  32'h00A000AF, 1, 3, 0};
    vec[12] = '{0, 0, 1, 64'h103, 64'h100, 64'h0,   32'h00000013, 0, 3, 1};
    vec[13] = '{0, 0, 0, 64'h0,   64'h104, 64'h100, 32'h00A00193, 1, 3, 1};
    vec[14] = '{0, 1, 1, 64'h40,  64'h40,  64'h0,   32'h00000013, 0, 3, 2};
    vec[15] = '{0, 0, 1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0, 32'h00000013, 0, 3, 3};
    vec[16] = '{0, 0, 0, 64'h0,   64'h0,   64'hFFFFFFFFFFFFFFFC, 32'h00A0008F, 1, 3, 3};
    vec[17] = '{0, 0, 0, 64'h0,   64'h4,   64'h0,   32'h00A00093, 1, 3, 3};
    vec[18] = '{0, 1, 0, 64'h0,   64'h4,   64'h0,   32'h00A00093, 1, 4, 3};
    vec[19] = '{1, 1, 0, 64'h0,   64'h0,   64'h0,   32'h00000013, 0, 0, 0};
    vec[20] = '{0, 0, 0, 64'h0,   64'h4,   64'h0,   32'h00A00093, 1, 0, 0};
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      reset = vec[i].r; stall = vec[i].s; branch_taken = vec[i].b; branch_target = vec[i].t;
      @(posedge clk); #1;
      check_state($sformatf("v%0d", i), vec[i]);
    end
    stall = 1'b1; reset = 1'b0; branch_taken = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      e = '{0, 1, 0, 64'h0, 64'h4, 64'h0, 32'h00A00093, 1, 32'(k), 0};
      check_state($sformatf("hold%0d", k), e);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    e = '{0, 0, 0, 64'h0, 64'h8, 64'h4, 32'h00A00097, 1, 5, 0};
    check_state("release", e);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
Instruction-fetch stage with the IF/ID pipeline register, directly upstream of the ID-stage load-use hazard check.
- Owns the PC and drives the instruction-memory address.
- Latches the fetched instruction into IF/ID.
- Exposes the decoded RS1/RS2 fields that the hazard check consumes.
- Obeys the hazard check's stall output and the EX-stage branch redirect/flush.

Parameters:
XLEN, 64, width of PC and addresses
RESET_PC, 0, PC value loaded on reset
NOP_INSTR, 32'h00000013, bubble instruction inserted on flush/reset (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
stall  input  1  load-use stall from hazard detection; hold PC and IF/ID
branch_taken  input  1  EX-stage redirect; flush IF/ID, load new PC
branch_target  input  XLEN  redirect address
instr_addr  output  XLEN  instruction-memory address (= current PC)
instr_in  input  32  instruction-memory read data, combinational from instr_addr
if_id_pc  output  XLEN  PC of instruction held in IF/ID
if_id_instr  output  32  instruction held in IF/ID
if_id_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble
if_id_rs1  output  5  if_id_instr[19:15], to hazard RS1
if_id_rs2  output  5  if_id_instr[24:20], to hazard RS2
stall_cycles  output  32  stall-cycle count (see Optional Feature)
flush_count  output  32  flush-event count (see Optional Feature)

Behaviour:
- One clock (clk). Reset is synchronous and active-high: sampled only on the rising clk edge while reset=1.
- Reset values:
  - pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - stall_cycles=0, flush_count=0.
- instr_addr = pc (combinational). instr_in is valid in the same cycle, so fetch latency into IF/ID is 1 cycle.
- if_id_rs1 and if_id_rs2 are pure combinational slices of if_id_instr, with no gating by valid.
- Per-edge priority: reset > branch_taken > stall > advance.
  - branch_taken=1:
    - pc <= {branch_target[XLEN-1:2],2'b00}.
    - if_id_instr <= NOP_INSTR, if_id_valid <= 0, if_id_pc <= 0.
    - Overrides a simultaneous stall: the stalled instruction is squashed anyway.
  - stall=1 (no branch): pc, if_id_pc, if_id_instr and if_id_valid all hold. Stall may persist any number of cycles.
  - advance:
    - pc <= pc + 4, modulo 2^XLEN; all-ones-aligned PC wraps to 0.
    - if_id_pc <= pc, if_id_instr <= instr_in, if_id_valid <= 1.
- The first instruction reaches IF/ID one edge after reset deasserts.
- Reset asserted mid-stall or mid-redirect: reset wins, and all state returns to reset values on that edge.
- No handshake with instruction memory: it is assumed single-cycle by design contract.

Optional Feature:
Macro FETCH_PERF_COUNTERS_EN.
- Defined:
  - stall_cycles increments by 1 on each edge where stall=1, branch_taken=0 and reset=0.
  - flush_count increments on each edge where branch_taken=1 and reset=0.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: no counter registers; both outputs are tied to 0. Port list is unchanged.

Test Plan:
- Reset then release; memory returns instr at addr A as 32'h00A00093+A. Required: instr_addr = 0,4,8 on successive cycles; if_id_pc = 0,4 with matching instructions; if_id_valid rises 1 cycle after reset release.
- Stall held 3 cycles with pc=8. Required: instr_addr stays 8; if_id_pc stays 4; if_id_instr unchanged; after release, pc advances to 12. With macro, stall_cycles=3.
- branch_taken=1 with branch_target=0x103 while pc=0x20. Required: next pc=0x100, if_id_instr=0x00000013, if_id_valid=0; next cycle if_id_pc=0x100.
- stall=1 and branch_taken=1 in the same cycle. Required: the redirect is taken and IF/ID is flushed. With macro, flush_count=1 and stall_cycles is not incremented.
- Load PC 64'hFFFFFFFFFFFFFFFC via a branch, then advance. Required: next pc=0.
- Assert reset during a 2-cycle stall. Required: pc=RESET_PC, if_id_valid=0 and counters=0 on the next edge.
